// File: rtl/uart_transmitter.sv
// uart_transmitter: serialises bytes accepted over valid/ready into 8N1 frames on tx.
// A one-entry holding register lets the next frame start the same edge the stop bit ends.
module uart_transmitter #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data_in,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic             tx_d, busy_d, done_d, in_ready_d;

   logic accept_c;
   logic bit_end_c;

   assign accept_c  = in_valid && in_ready;
   assign bit_end_c = (cnt_q == CNT_MAX);

   // State, datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         tx          <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
         in_ready    <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         tx          <= tx_d;
         busy        <= busy_d;
         done        <= done_d;
         in_ready    <= in_ready_d;
      end
   end

   // Next-state, bit timing, holding register and next output values
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      done_d      = 1'b0;
      tx_d        = 1'b1;
      busy_d      = 1'b0;
      in_ready_d  = 1'b1;

      // A byte accepted mid-frame parks in the holding register
      if (state_q != IDLE && accept_c) begin
         hold_d      = data_in;
         hold_full_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (accept_c) begin
               shift_d = data_in;
               cnt_d   = '0;
               state_d = START;
            end
         end
         START: begin
            if (bit_end_c) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DATA: begin
            if (bit_end_c) begin
               cnt_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = shift_q >> 1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STOP: begin
            if (bit_end_c) begin
               cnt_d  = '0;
               done_d = 1'b1;
               if (hold_full_q) begin
                  shift_d     = hold_q;
                  hold_full_d = 1'b0;
                  state_d     = START;
               end else if (accept_c) begin
                  // Same-edge offer goes straight to the shifter, not the holding register
                  shift_d     = data_in;
                  hold_full_d = 1'b0;
                  state_d     = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
      busy_d     = (state_d != IDLE);
      in_ready_d = !hold_full_d;
   end

endmodule
